// File: rtl/data_bus_arbiter_pkg.sv
// rtl/data_bus_arbiter_pkg.sv - shared types and address map for the data-port arbiter and decoder
package data_bus_arbiter_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOCK0 = 2'd1;
    localparam state_t ST_LOCK1 = 2'd2;

    // 0 = core LSU, 1 = DMA
    typedef logic master_idx_t;

    localparam logic [31:0] IO_BASE  = 32'h8000_0000;
    localparam logic [31:0] IO_LIMIT = 32'h8000_6000;

    function automatic logic addr_is_valid(input logic [31:0] addr, input logic [31:0] ram_size);
        return (addr < ram_size) || ((addr >= IO_BASE) && (addr < IO_LIMIT));
    endfunction

endpackage

// File: rtl/data_bus_rr_pick.sv
// rtl/data_bus_rr_pick.sv - combinational two-way round-robin pick with eligibility mask
module data_bus_rr_pick
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t ptr,
    input  logic [1:0]  mask,
    output logic [1:0]  gnt
);

    logic [1:0] elig;

    always_comb begin
        elig = req & mask;
        gnt  = 2'b00;
        case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master data-port arbiter with lock bursts and address checking
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int unsigned RAM_SIZE  = 256,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_lock_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m1_req_i,
    input  logic        m1_lock_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(BURST_MAX);
    localparam logic [CW-1:0] CNT_REL = CW'(BURST_MAX - 1);

    state_t      state_q, state_d;
    master_idx_t ptr_q, ptr_d;
    master_idx_t owner;
    master_idx_t gnt_idx;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    logic [1:0]  req, lock, mask, gnt;
    logic        any_gnt, we_sel, sel_valid;
    logic [3:0]  be_sel;
    logic [31:0] addr_sel, wdata_sel;

    logic [1:0]  rvalid_q, err_q;
    logic [31:0] rdata0_q, rdata1_q;

    assign req   = {m1_req_i, m0_req_i};
    assign lock  = {m1_lock_i, m0_lock_i};
    assign owner = (state_q == ST_LOCK1);

    // Reset masks every master so nothing reaches the slave while rst_i is high.
    always_comb begin
        mask = 2'b00;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE:  mask = 2'b11;
                ST_LOCK0: mask = 2'b01;
                ST_LOCK1: mask = 2'b10;
                default:  mask = 2'b00;
            endcase
        end
    end

    data_bus_rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .mask (mask),
        .gnt  (gnt)
    );

    assign any_gnt   = |gnt;
    assign gnt_idx   = gnt[1];
    assign we_sel    = gnt_idx ? m1_we_i    : m0_we_i;
    assign be_sel    = gnt_idx ? m1_be_i    : m0_be_i;
    assign addr_sel  = gnt_idx ? m1_addr_i  : m0_addr_i;
    assign wdata_sel = gnt_idx ? m1_wdata_i : m0_wdata_i;
    assign sel_valid = addr_is_valid(addr_sel, RAM_SIZE);

    assign m0_gnt_o  = gnt[0];
    assign m1_gnt_o  = gnt[1];
    assign s_req_o   = any_gnt && sel_valid;
    assign s_we_o    = any_gnt && we_sel;
    assign s_be_o    = any_gnt ? be_sel    : 4'h0;
    assign s_addr_o  = any_gnt ? addr_sel  : 32'h0;
    assign s_wdata_o = any_gnt ? wdata_sel : 32'h0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (any_gnt) begin
                    if (lock[gnt_idx]) begin
                        state_d = gnt_idx ? ST_LOCK1 : ST_LOCK0;
                        cnt_d   = '0;
                    end else begin
                        ptr_d = ~gnt_idx;
                    end
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                cnt_d = cnt_inc;
                // Forced release once the post-increment count hits BURST_MAX-1 with the other master waiting.
                if ((gnt[owner] && !lock[owner]) || (req[~owner] && (cnt_inc >= CNT_REL))) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~owner;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            err_q    <= gnt & {2{~sel_valid}};
            rdata0_q <= (gnt[0] && sel_valid && !we_sel) ? s_rdata_i : 32'h0;
            rdata1_q <= (gnt[1] && sel_valid && !we_sel) ? s_rdata_i : 32'h0;
        end
    end

    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_err_o    = err_q[0];
    assign m1_err_o    = err_q[1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

    localparam int RAM_SIZE  = 256;
    localparam int BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < RAM_SIZE) || ((a >= 32'h8000_0000) && (a < 32'h8000_6000));
    endfunction

    assign s_rdata = s_req ? rdata_of(s_addr) : 32'hDEAD_BEEF;

    data_bus_arbiter #(.RAM_SIZE(RAM_SIZE), .BURST_MAX(BURST_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_rdata_i(s_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference: who owns the bus (-1 = nobody), lock beats so far, round-robin turn, responses due next cycle.
    int          owner = -1;
    int          held  = 0;
    int          turn  = 0;
    bit          resp_known = 0;
    logic        exp_rv[2];
    logic        exp_err[2];
    logic [31:0] exp_rd[2];

    logic        obs_g0, obs_g1, obs_rv1;

    logic [31:0] edges[8] = '{32'h0, 32'h0000_00FF, 32'h0000_0100, 32'h7FFF_FFFF,
                              32'h8000_0000, 32'h8000_5FFF, 32'h8000_6000, 32'hFFFF_FFFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input bit req, input bit lock, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (k == 0) begin
            m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
    endtask

    task automatic idle_both();
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic        r[2], l[2], w[2];
        logic [3:0]  b[2];
        logic [31:0] a[2], d[2];
        int g;
        bit v;
        #1;
        r[0] = m0_req;  l[0] = m0_lock; w[0] = m0_we; b[0] = m0_be; a[0] = m0_addr; d[0] = m0_wdata;
        r[1] = m1_req;  l[1] = m1_lock; w[1] = m1_we; b[1] = m1_be; a[1] = m1_addr; d[1] = m1_wdata;

        if (rst)                 g = -1;
        else if (owner >= 0)     g = r[owner] ? owner : -1;
        else if (r[0] && r[1])   g = turn;
        else if (r[0])           g = 0;
        else if (r[1])           g = 1;
        else                     g = -1;
        v = 0;
        if (g >= 0) v = addr_ok(a[g]);

        obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv1 = m1_rvalid;
        check("m0_gnt", m0_gnt, g == 0);
        check("m1_gnt", m1_gnt, g == 1);
        check("s_req", s_req, v);
        check("s_we", s_we, (g >= 0) ? w[g] : 1'b0);
        check("s_be", s_be, (g >= 0) ? b[g] : 4'h0);
        check("s_addr", s_addr, (g >= 0) ? a[g] : 32'h0);
        check("s_wdata", s_wdata, (g >= 0) ? d[g] : 32'h0);
        if (resp_known) begin
            check("m0_rvalid", m0_rvalid, exp_rv[0]);
            check("m0_err", m0_err, exp_err[0]);
            check("m0_rdata", m0_rdata, exp_rd[0]);
            check("m1_rvalid", m1_rvalid, exp_rv[1]);
            check("m1_err", m1_err, exp_err[1]);
            check("m1_rdata", m1_rdata, exp_rd[1]);
        end

        if (rst) begin
            owner = -1; held = 0; turn = 0;
            for (int k = 0; k < 2; k++) begin
                exp_rv[k] = 0; exp_err[k] = 0; exp_rd[k] = 32'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_rv[k]  = (g == k);
                exp_err[k] = (g == k) && !v;
                exp_rd[k]  = ((g == k) && v && !w[k]) ? rdata_of(a[k]) : 32'h0;
            end
            if (owner < 0) begin
                if (g >= 0) begin
                    if (l[g]) begin
                        owner = g; held = 0;
                    end else begin
                        turn = 1 - g;
                    end
                end
            end else begin
                held = (held + 1 > BURST_MAX) ? BURST_MAX : held + 1;
                if ((g == owner && !l[owner]) || (r[1 - owner] && held >= BURST_MAX - 1)) begin
                    turn = 1 - owner; owner = -1; held = 0;
                end
            end
        end
        resp_known = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return $urandom_range(0, RAM_SIZE - 1);
            3, 4:    return 32'h8000_0000 + $urandom_range(0, 32'h5FFF);
            5, 6:    return edges[$urandom_range(0, 7)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int m1_beats;
        idle_both();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Requests while held in reset must not be granted.
        set_m(0, 1, 0, 0, 32'h10, 32'h0, 4'hF);
        set_m(1, 1, 0, 0, 32'h20, 32'h0, 4'hF);
        step();
        rst = 1'b0;

        // Simultaneous reads after reset: m0 first, then m1.
        step();
        check("first_m0_wins", obs_g0, 1'b1);
        check("first_m1_held", obs_g1, 1'b0);
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step();
        check("second_m1_wins", obs_g1, 1'b1);
        idle_both();
        step();

        // Back-to-back reads from m0.
        for (int i = 0; i < 3; i++) begin
            set_m(0, 1, 0, 0, 32'(4 * i), 32'h0, 4'hF);
            step();
        end
        idle_both();
        step();

        // Write outside the map.
        set_m(0, 1, 0, 1, 32'h9000_0000, 32'h1234_5678, 4'hF);
        step();
        idle_both();
        step();

        // Address-map boundaries, read and write.
        for (int i = 0; i < 8; i++) begin
            set_m(0, 1, 0, i[0], edges[i], 32'hA5A5_0000 + 32'(i), 4'(i + 1));
            step();
        end
        idle_both();
        step();

        // m1 locked burst against a waiting m0.
        m1_beats = 0;
        for (int i = 0; i < 12; i++) begin
            set_m(0, 1, 0, 0, 32'h80, 32'h0, 4'hF);
            set_m(1, 1, 1, 0, 32'h40 + 32'(4 * i), 32'h0, 4'hF);
            step();
            if (i < 8 && obs_g1) m1_beats++;
            if (i == 8) check("burst_release_m0", obs_g0, 1'b1);
        end
        check("burst_m1_beats", m1_beats, 8);

        // Reset while m1 holds the lock with a read just granted.
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1, 1, 0, 32'h44, 32'h0, 4'hF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_m(0, 1, 0, 0, 32'h8, 32'h0, 4'hF);
        set_m(1, 1, 0, 0, 32'hC, 32'h0, 4'hF);
        step();
        check("post_rst_m0_gnt", obs_g0, 1'b1);
        check("post_rst_no_m1_rvalid", obs_rv1, 1'b0);

        // Randomised traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++)
                set_m(k, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      pick_addr(), $urandom, 4'($urandom));
            step();
        end
        rst = 1'b0;
        idle_both();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
